key_beep_pattern: RTL
=====================

Name: key_beep_pattern

Overview:
- Downstream consumer of the key debounce stage.
- Takes the one-cycle key_flag pulse produced after debouncing and drives the passive buzzer with a fixed pattern: BEEP_NUM tone bursts of ON_CYC cycles, separated by silent gaps of OFF_CYC cycles.
- The tone is a square wave with a half-period of TONE_HALF cycles.
- Replaces the simple level-follow beep control in the key/beep top.

Parameters:
- TONE_HALF, 20'd4: tone half-period in sys_clk cycles; must be >= 1.
- ON_CYC, 20'd16: length of each tone burst in cycles; must be >= 1.
- OFF_CYC, 20'd8: silent gap between bursts in cycles; must be >= 1.
- BEEP_NUM, 4'd3: bursts per trigger; range 1..15.
- Defaults are sized for simulation. Board builds override them, e.g. TONE_HALF=20'd25000, ON_CYC=20'd500000 etc. at 50 MHz.

Ports:
- sys_clk, input, 1: system clock. This is the only clock.
- sys_rst, input, 1: reset, synchronous and active-high.
- key_flag, input, 1: one-cycle pulse from the debounce stage marking a valid press.
- beep, output, 1: buzzer drive; 1 = driver on; idle 0.
- busy, output, 1: high while a pattern is playing.
- done, output, 1: one-cycle pulse when a pattern completes normally.
- beep_idx, output, 4: index of the current burst, 0..BEEP_NUM-1; 0 when idle.

Behaviour:
- Clocking and reset:
  - All outputs are registered. Everything updates on the sys_clk rising edge only.
  - sys_rst=1 sampled at an edge: state<=IDLE, beep<=0, busy<=0, done<=0, beep_idx<=0, all counters<=0.
  - sys_rst has priority over everything, including mid-pattern. A reset-aborted pattern produces no done pulse.
- Internal counters:
  - dur_cnt, 20 bits: position within the current ON or OFF segment.
  - ph_cnt, 20 bits: position within the current tone half-period.
  - Counters compare against PARAM-1 and return to 0 on reaching it. They never exceed the parameter.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - beep=0, busy=0.
  - On an edge sampling key_flag=1: state<=ON, busy<=1, beep<=1, dur_cnt<=0, ph_cnt<=0, beep_idx<=0.
  - Latency from the key_flag sample edge to beep=1 is one edge, i.e. visible in the following cycle.
- ON:
  - Each edge, dur_cnt increments.
  - When ph_cnt==TONE_HALF-1: ph_cnt<=0 and beep toggles. Otherwise ph_cnt increments.
  - When dur_cnt==ON_CYC-1, this overrides the tone toggle and beep<=0:
    - If beep_idx==BEEP_NUM-1: state<=IDLE, busy<=0, done<=1, beep_idx<=0.
    - Otherwise: state<=OFF, dur_cnt<=0.
- OFF:
  - beep=0.
  - When dur_cnt==OFF_CYC-1: state<=ON, dur_cnt<=0, ph_cnt<=0, beep<=1, beep_idx<=beep_idx+1.
  - Otherwise dur_cnt increments.
- done is high for exactly one cycle, coincident with the first cycle of busy=0.
- Total busy length: BEEP_NUM*ON_CYC + (BEEP_NUM-1)*OFF_CYC cycles. With defaults this is 64.
- Each burst starts with beep=1 and tone phase reset. For TONE_HALF=4, ON_CYC=16 the per-burst beep sequence is 1111 0000 1111 0000.
- key_flag handling:
  - key_flag while busy=1 is ignored, including on the final ON cycle. No queuing, no restart.
  - key_flag sampled in the cycle where done=1 (busy already 0) starts a new pattern.
- Corner parameter values:
  - TONE_HALF >= ON_CYC: each burst is a single high level of ON_CYC cycles, with no toggle inside the burst.
  - BEEP_NUM=1: the pattern is IDLE->ON->IDLE and never enters OFF.

Test Plan:
- Reset check: hold sys_rst=1 for 10 cycles while key_flag toggles. Required: beep=0, busy=0, done=0, beep_idx=0 throughout.
- Default pattern: single key_flag pulse at cycle T. Required:
  - busy high from T+1 for 64 cycles.
  - beep follows 1111 0000 1111 0000, then 8 zeros, repeated for 3 bursts with no trailing gap.
  - beep_idx steps 0,1,2.
  - done=1 at T+65 only.
- Ignore while busy: key_flag pulses at burst 1 mid-ON, mid-OFF, and on the last ON cycle. Required: pattern identical to the previous scenario, a single done pulse, no restart.
- Back-to-back: key_flag asserted in the same cycle done=1. Required: a new 64-cycle pattern starts with beep=1 on the next cycle; busy low for exactly 1 cycle between patterns.
- Reset mid-pattern: assert sys_rst for 1 cycle during burst 2 OFF. Required: next cycle state IDLE, beep=0, busy=0, beep_idx=0, no done. A subsequent key_flag plays a full fresh pattern.
- Parameter override: TONE_HALF=20, ON_CYC=10, OFF_CYC=3, BEEP_NUM=1. Required: beep high for exactly 10 cycles, then done; busy for 10 cycles; OFF never entered.

Source files
------------

// File: rtl/key_beep_pattern.sv
// Key-triggered buzzer pattern: BEEP_NUM tone bursts of ON_CYC cycles separated by OFF_CYC gaps.
// The tone is a square wave of half-period TONE_HALF that restarts high at the start of every burst.
module key_beep_pattern #(
  parameter logic [19:0] TONE_HALF = 20'd4,
  parameter logic [19:0] ON_CYC    = 20'd16,
  parameter logic [19:0] OFF_CYC   = 20'd8,
  parameter logic [3:0]  BEEP_NUM  = 4'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_flag,
  output logic       beep,
  output logic       busy,
  output logic       done,
  output logic [3:0] beep_idx,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [19:0] dur_cnt, dur_nx;
  logic [19:0] ph_cnt, ph_nx;
  logic        beep_nx, busy_nx, done_nx;
  logic [3:0]  idx_nx;

  assign state_dbg = state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      dur_cnt  <= 20'd0;
      ph_cnt   <= 20'd0;
      beep     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beep_idx <= 4'd0;
    end else begin
      state    <= state_nx;
      dur_cnt  <= dur_nx;
      ph_cnt   <= ph_nx;
      beep     <= beep_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      beep_idx <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dur_nx   = dur_cnt;
    ph_nx    = ph_cnt;
    beep_nx  = beep;
    busy_nx  = busy;
    done_nx  = 1'b0;
    idx_nx   = beep_idx;
    case (state)
      IDLE: begin
        beep_nx = 1'b0;
        busy_nx = 1'b0;
        if (key_flag) begin
          state_nx = ON;
          busy_nx  = 1'b1;
          beep_nx  = 1'b1;
          dur_nx   = 20'd0;
          ph_nx    = 20'd0;
          idx_nx   = 4'd0;
        end
      end
      ON: begin
        dur_nx = dur_cnt + 20'd1;
        if (ph_cnt == TONE_HALF - 20'd1) begin
          ph_nx   = 20'd0;
          beep_nx = ~beep;
        end else begin
          ph_nx = ph_cnt + 20'd1;
        end
        // End of burst wins over a tone toggle landing on the same edge.
        if (dur_cnt == ON_CYC - 20'd1) begin
          beep_nx = 1'b0;
          dur_nx  = 20'd0;
          if (beep_idx == BEEP_NUM - 4'd1) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            idx_nx   = 4'd0;
            ph_nx    = 20'd0;
          end else begin
            state_nx = OFF;
          end
        end
      end
      OFF: begin
        beep_nx = 1'b0;
        if (dur_cnt == OFF_CYC - 20'd1) begin
          state_nx = ON;
          dur_nx   = 20'd0;
          ph_nx    = 20'd0;
          beep_nx  = 1'b1;
          idx_nx   = beep_idx + 4'd1;
        end else begin
          dur_nx = dur_cnt + 20'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        beep_nx  = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule
